// File: rtl/speed_controller.sv
// Game speed controller: converts pedal levels into a saturating speed,
// applies a timed crash penalty, and accumulates travelled distance.
module speed_controller #(
  parameter int unsigned MAX_SPEED     = 20,
  parameter int unsigned RESTART_SPEED = 2,
  parameter int unsigned ACCEL_FRAMES  = 4,
  parameter int unsigned DECEL_FRAMES  = 2,
  parameter int unsigned COAST_FRAMES  = 8,
  parameter int unsigned CRASH_FRAMES  = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startGame,
  input  logic        accelerate,
  input  logic        brake,
  input  logic        collision,
  input  logic        gameOver,
  output logic [4:0]  speed,
  output logic        crashActive,
  output logic [15:0] distance
);

  localparam int unsigned PMAX_AD = (ACCEL_FRAMES > DECEL_FRAMES) ? ACCEL_FRAMES : DECEL_FRAMES;
  localparam int unsigned PMAX    = (PMAX_AD > COAST_FRAMES) ? PMAX_AD : COAST_FRAMES;
  localparam int unsigned CNT_W   = (PMAX < 1) ? 1 : $clog2(PMAX + 1);
  localparam int unsigned CR_W    = (CRASH_FRAMES < 1) ? 1 : $clog2(CRASH_FRAMES + 1);

  localparam logic [4:0]       MAX_S     = 5'(MAX_SPEED);
  localparam logic [4:0]       RESTART_S = 5'(RESTART_SPEED);
  localparam logic [CNT_W-1:0] ACCEL_P   = CNT_W'(ACCEL_FRAMES);
  localparam logic [CNT_W-1:0] DECEL_P   = CNT_W'(DECEL_FRAMES);
  localparam logic [CNT_W-1:0] COAST_P   = CNT_W'(COAST_FRAMES);
  localparam logic [CR_W-1:0]  CRASH_P   = CR_W'(CRASH_FRAMES);

  typedef enum logic [1:0] {IDLE_ST, RUN_ST, CRASH_ST, OVER_ST} state_t;
  typedef enum logic [1:0] {COAST_M, ACCEL_M, BRAKE_M} mode_t;

  state_t           state_q;
  mode_t            prev_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CR_W-1:0]  crash_cnt_q;
  logic [4:0]       speed_q;
  logic             crash_q;
  logic [15:0]      dist_q;

  mode_t            mode_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] period_d;
  logic             step_d;
  logic [4:0]       speed_step_d;
  logic [16:0]      dist_sum_d;
  logic [15:0]      dist_d;
  logic [CR_W-1:0]  crash_cnt_d;

  // Per-frame pedal evaluation: mode, step counter, stepped speed and distance.
  always_comb begin
    mode_d = COAST_M;
    if (brake) begin
      mode_d = BRAKE_M;
    end else if (accelerate) begin
      mode_d = ACCEL_M;
    end

    cnt_d = (mode_d != prev_q) ? CNT_W'(1) : cnt_q + CNT_W'(1);

    case (mode_d)
      ACCEL_M: period_d = ACCEL_P;
      BRAKE_M: period_d = DECEL_P;
      default: period_d = COAST_P;
    endcase
    step_d = (cnt_d == period_d);

    speed_step_d = speed_q;
    if (mode_d == ACCEL_M) begin
      if (speed_q < MAX_S) speed_step_d = speed_q + 5'd1;
    end else begin
      if (speed_q != '0) speed_step_d = speed_q - 5'd1;
    end

    // Distance accumulates the speed held before this frame's step.
    dist_sum_d  = {1'b0, dist_q} + {12'd0, speed_q};
    dist_d      = dist_sum_d[16] ? '1 : dist_sum_d[15:0];
    crash_cnt_d = crash_cnt_q + CR_W'(1);
  end

  // Main FSM with registered outputs; priority gameOver > collision > startGame > frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE_ST;
      prev_q      <= COAST_M;
      cnt_q       <= '0;
      crash_cnt_q <= '0;
      speed_q     <= '0;
      crash_q     <= 1'b0;
      dist_q      <= '0;
    end else if (gameOver && state_q != IDLE_ST) begin
      state_q <= OVER_ST;
      speed_q <= '0;
      crash_q <= 1'b0;
    end else if (!gameOver) begin
      case (state_q)
        IDLE_ST, OVER_ST: begin
          if (startGame) begin
            state_q     <= RUN_ST;
            speed_q     <= RESTART_S;
            dist_q      <= '0;
            cnt_q       <= '0;
            crash_cnt_q <= '0;
            prev_q      <= COAST_M;
            crash_q     <= 1'b0;
          end
        end
        RUN_ST: begin
          if (collision) begin
            state_q     <= CRASH_ST;
            speed_q     <= '0;
            crash_q     <= 1'b1;
            crash_cnt_q <= '0;
          end else if (startOfFrame) begin
            prev_q <= mode_d;
            dist_q <= dist_d;
            if (step_d) begin
              speed_q <= speed_step_d;
              cnt_q   <= '0;
            end else begin
              cnt_q   <= cnt_d;
            end
          end
        end
        CRASH_ST: begin
          if (startOfFrame) begin
            if (crash_cnt_d == CRASH_P) begin
              state_q     <= RUN_ST;
              speed_q     <= RESTART_S;
              crash_q     <= 1'b0;
              cnt_q       <= '0;
              prev_q      <= COAST_M;
              crash_cnt_q <= '0;
            end else begin
              crash_cnt_q <= crash_cnt_d;
            end
          end
        end
        default: state_q <= IDLE_ST;
      endcase
    end
  end

  assign speed       = speed_q;
  assign crashActive = crash_q;
  assign distance    = dist_q;

endmodule

// File: tb/tb_speed_controller.sv
// Directed scoreboard bench for speed_controller.
module tb_speed_controller;

  logic        clk = 1'b0;
  logic        resetN, startOfFrame, startGame, accelerate, brake, collision, gameOver;
  logic [4:0]  speed;
  logic        crashActive;
  logic [15:0] distance;

  typedef struct {
    string       nm;
    logic [4:0]  s;
    logic        c;
    logic [15:0] d;
  } exp_t;

  exp_t q[$];
  int unsigned checks   = 0;
  int unsigned failures = 0;
  event chk_ev;

  speed_controller #(
    .MAX_SPEED(20), .RESTART_SPEED(2), .ACCEL_FRAMES(4),
    .DECEL_FRAMES(2), .COAST_FRAMES(8), .CRASH_FRAMES(60)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
    .accelerate(accelerate), .brake(brake), .collision(collision), .gameOver(gameOver),
    .speed(speed), .crashActive(crashActive), .distance(distance)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are sampled away from the rising edge and compared to queued expectations.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      while (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (speed !== e.s || crashActive !== e.c || distance !== e.d) begin
          failures++;
          $display("FAIL %s: got speed=%0d crash=%0b dist=%0d, want speed=%0d crash=%0b dist=%0d",
                   e.nm, speed, crashActive, distance, e.s, e.c, e.d);
        end
      end
    end
  end

  task automatic tick(input logic sof, input logic sg, input logic acc, input logic brk,
                      input logic col, input logic go);
    startOfFrame = sof; startGame = sg; accelerate = acc;
    brake = brk; collision = col; gameOver = go;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_o(input string nm, input logic [4:0] s, input logic c,
                          input logic [15:0] d);
    exp_t e;
    e.nm = nm; e.s = s; e.c = c; e.d = d;
    q.push_back(e);
  endtask

  // n frames with the given pedals, a startOfFrame pulse every other cycle.
  task automatic frames(input int unsigned n, input logic acc, input logic brk);
    for (int unsigned i = 0; i < n; i++) begin
      tick(1'b1, 1'b0, acc, brk, 1'b0, 1'b0);
      tick(1'b0, 1'b0, acc, brk, 1'b0, 1'b0);
    end
  endtask

  initial begin
    resetN = 1'b0;
    startOfFrame = 0; startGame = 0; accelerate = 0; brake = 0; collision = 0; gameOver = 0;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    expect_o("reset", 5'd0, 1'b0, 16'd0);
    @(negedge clk);
    resetN = 1'b1;

    // Start
    tick(0, 1, 0, 0, 0, 0);
    expect_o("start", 5'd2, 1'b0, 16'd0);

    // Accelerate 8 frames: step at frame 4 and 8; distance 2*4 + 3*4
    frames(4, 1, 0);
    expect_o("accel_f4", 5'd3, 1'b0, 16'd8);
    frames(4, 1, 0);
    expect_o("accel_f8", 5'd4, 1'b0, 16'd20);

    // Accelerate 200 frames: saturates at 20; distance 20 + 4*(4..19) + 136*20
    frames(200, 1, 0);
    expect_o("accel_sat", 5'd20, 1'b0, 16'd3476);
    // Brake 4 frames: adds 20+20+19+19
    frames(4, 0, 1);
    expect_o("brake4", 5'd18, 1'b0, 16'd3554);
    // Brake 16 more frames to speed 10: adds 2*(11..18)
    frames(16, 0, 1);
    expect_o("brake_to10", 5'd10, 1'b0, 16'd3786);

    // Collision together with startOfFrame: frame work discarded
    tick(1, 0, 0, 0, 1, 0);
    expect_o("collide", 5'd0, 1'b1, 16'd3786);
    tick(0, 0, 0, 0, 0, 0);
    frames(29, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    expect_o("crash_ignore_col", 5'd0, 1'b1, 16'd3786);
    frames(30, 1, 0);
    expect_o("crash_f59", 5'd0, 1'b1, 16'd3786);
    frames(1, 0, 0);
    expect_o("crash_recover", 5'd2, 1'b0, 16'd3786);

    // gameOver + collision together: gameOver wins
    tick(0, 0, 0, 0, 1, 1);
    expect_o("over", 5'd0, 1'b0, 16'd3786);
    frames(3, 1, 0);
    expect_o("over_frozen", 5'd0, 1'b0, 16'd3786);
    tick(0, 1, 0, 0, 0, 1);
    expect_o("over_start_blocked", 5'd0, 1'b0, 16'd3786);
    tick(0, 1, 0, 0, 0, 0);
    expect_o("restart", 5'd2, 1'b0, 16'd0);

    // Coast: -1 every 8 frames, saturating at 0
    frames(8, 0, 0);
    expect_o("coast8", 5'd1, 1'b0, 16'd16);
    frames(8, 0, 0);
    expect_o("coast16", 5'd0, 1'b0, 16'd24);
    frames(8, 0, 0);
    expect_o("coast_floor", 5'd0, 1'b0, 16'd24);

    // Reset mid-crash at frame 30
    tick(0, 0, 0, 0, 1, 0);
    expect_o("crash2", 5'd0, 1'b1, 16'd24);
    frames(30, 0, 0);
    #1;
    resetN = 1'b0;
    #1;
    expect_o("async_reset", 5'd0, 1'b0, 16'd0);
    ->chk_ev;
    #1;
    @(negedge clk);
    resetN = 1'b1;
    frames(3, 1, 0);
    expect_o("idle_ignores_sof", 5'd0, 1'b0, 16'd0);
    tick(0, 0, 0, 0, 0, 1);
    expect_o("idle_ignores_over", 5'd0, 1'b0, 16'd0);
    tick(0, 1, 0, 0, 0, 0);
    expect_o("start_after_reset", 5'd2, 1'b0, 16'd0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
